// File: rtl/proc_mem_pkg.sv
// Shared definitions for the processor memory responder: FSM encoding,
// default geometry and the rw bus encoding.
package proc_mem_pkg;

  localparam int          DEF_ADDR_W    = 6;
  localparam int          DEF_TIMEOUT   = 15;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/proc_mem_responder_if.sv
// Processor-side bus, preload port and status outputs of the responder.
interface proc_mem_responder_if
  import proc_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic [31:0]       instruction;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              rw;
  logic              sys_dne;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              start;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              err;

  // master: processor / loader side
  modport master (
    input  instruction, pc, halted, err,
    output addr, wdata, rw, sys_dne, ld_en, ld_addr, ld_data, start
  );

  // slave: the responder
  modport slave (
    output instruction, pc, halted, err,
    input  addr, wdata, rw, sys_dne, ld_en, ld_addr, ld_data, start
  );

endinterface

// File: rtl/proc_mem_array.sv
// 2^ADDR_W x 32 program/data store: one synchronous write port and one
// asynchronous read port.
module proc_mem_array #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // NOTE: the array has no reset; a cleared memory would cost a full-depth
  // reset tree and the loaded program must survive a reset anyway.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/proc_mem_responder.sv
// Memory responder that preloads a program, feeds it word by word to a
// processor, services its data writes and watches for stalls.
module proc_mem_responder
  import proc_mem_pkg::*;
#(
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter int          TIMEOUT   = DEF_TIMEOUT,
  parameter logic [31:0] HALT_WORD = DEF_HALT_WORD
) (
  input logic                 clk,
  input logic                 reset,
  proc_mem_responder_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       instruction;
  logic              halted;
  logic              err;
  logic [CNT_W-1:0]  exec_cnt;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [31:0]       fetch_word;

  // Only the low address bits select a word.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_W];

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.ld_addr;
    mem_wdata = bus.ld_data;
    if (!reset) begin
      case (state)
        LOAD: mem_we = bus.ld_en;
        EXEC: begin
          if (bus.sys_dne && bus.rw == RW_WRITE) begin
            mem_we    = 1'b1;
            mem_waddr = bus.addr[ADDR_W-1:0];
            mem_wdata = bus.wdata;
          end
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  proc_mem_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (pc),
    .rdata (fetch_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      pc          <= '0;
      instruction <= '0;
      halted      <= 1'b0;
      err         <= 1'b0;
      exec_cnt    <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.start) state <= FETCH;
        end
        FETCH: begin
          if (fetch_word == HALT_WORD) begin
            instruction <= '0;
            halted      <= 1'b1;
            state       <= HALT;
          end else begin
            instruction <= fetch_word;
            pc          <= pc + ADDR_W'(1);
            exec_cnt    <= '0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          // Completion on the last allowed cycle still beats the timeout.
          if (bus.sys_dne) begin
            state <= FETCH;
          end else if (exec_cnt == CNT_W'(TIMEOUT - 1)) begin
            err         <= 1'b1;
            halted      <= 1'b1;
            instruction <= '0;
            state       <= HALT;
          end else begin
            exec_cnt <= exec_cnt + CNT_W'(1);
          end
        end
        HALT:    state <= HALT;
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.instruction = instruction;
  assign bus.pc          = pc;
  assign bus.halted      = halted;
  assign bus.err         = err;

endmodule

// File: tb/tb_proc_mem_responder.sv
// Scoreboard bench for proc_mem_responder: the stimulus side predicts each
// output change from a word-array model; the monitor checks every cycle.
module tb_proc_mem_responder;

  localparam int          AW    = 6;
  localparam int          DEPTH = 64;
  localparam int          TMO   = 15;
  localparam logic [31:0] HW    = 32'hFFFF_FFFF;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  proc_mem_responder_if #(.ADDR_W(AW)) bus ();

  proc_mem_responder #(
    .ADDR_W    (AW),
    .TIMEOUT   (TMO),
    .HALT_WORD (HW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] instr;
    int          pc;
    logic        halted;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   armed = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  // Reference model: plain word array plus program counter.
  logic [31:0] mem_m [DEPTH];
  int          pc_m   = 0;
  bit          halt_m = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    else
      passed++;
  endtask

  // Monitor: outputs only change at predicted edges, so between them they
  // must keep matching the most recent expectation.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      check("sb_due_cycle", 32'(cyc), 32'(sb[0].due));
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      cur   = sb.pop_front();
      armed = 1'b1;
    end
    if (armed) begin
      check("instruction", bus.instruction, cur.instr);
      check("pc",          32'(bus.pc),     32'(cur.pc));
      check("halted",      32'(bus.halted), 32'(cur.halted));
      check("err",         32'(bus.err),    32'(cur.err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.addr    = '0;
    bus.wdata   = '0;
    bus.rw      = 1'b0;
    bus.sys_dne = 1'b0;
    bus.ld_en   = 1'b0;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    bus.start   = 1'b0;
  endtask

  task automatic noise_inputs(input bit dne);
    bus.addr    = $urandom;
    bus.wdata   = $urandom;
    bus.rw      = 1'($urandom);
    bus.sys_dne = dne;
    bus.ld_en   = 1'($urandom);
    bus.ld_addr = AW'($urandom);
    bus.ld_data = $urandom;
    bus.start   = 1'($urandom);
  endtask

  task automatic push(input int due, input logic [31:0] instr, input int pc,
                      input logic h, input logic e);
    exp_t x;
    x.due = due; x.instr = instr; x.pc = pc; x.halted = h; x.err = e;
    sb.push_back(x);
  endtask

  // Predicted result of the FETCH that completes at cycle 'due'.
  task automatic fetch_expect(input int due);
    if (mem_m[pc_m] == HW) begin
      push(due, 32'h0, pc_m, 1'b1, 1'b0);
      halt_m = 1'b1;
    end else begin
      pc_m = (pc_m + 1) % DEPTH;
      push(due, mem_m[(pc_m + DEPTH - 1) % DEPTH], pc_m, 1'b0, 1'b0);
    end
  endtask

  // Caller may leave bus inputs active; reset must override them.
  task automatic do_reset();
    reset = 1'b1;
    push(cyc + 1, 32'h0, 0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    idle_inputs();
    pc_m   = 0;
    halt_m = 1'b0;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_addr = AW'(a);
    bus.ld_data = d;
    mem_m[a]    = d;
    tick();
    bus.ld_en = 1'b0;
  endtask

  // Pulse start (optionally with a last preload in the same cycle) and
  // return once the first word is presented.
  task automatic start_run(input bit with_ld, input int a, input logic [31:0] d);
    bus.start = 1'b1;
    if (with_ld) begin
      bus.ld_en   = 1'b1;
      bus.ld_addr = AW'(a);
      bus.ld_data = d;
      mem_m[a]    = d;
    end
    fetch_expect(cyc + 2);
    tick();
    idle_inputs();
    tick();
  endtask

  // Stall 'waitc' EXEC cycles under noise, then complete (optionally writing).
  task automatic exec_step(input int waitc, input bit wr, input logic [31:0] a,
                           input logic [31:0] d);
    repeat (waitc) begin
      noise_inputs(1'b0);
      tick();
    end
    idle_inputs();
    bus.sys_dne = 1'b1;
    bus.rw      = wr;
    bus.addr    = a;
    bus.wdata   = d;
    if (wr) mem_m[a % DEPTH] = d;
    fetch_expect(cyc + 2);
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic timeout_step();
    push(cyc + TMO, 32'h0, pc_m, 1'b1, 1'b1);
    halt_m = 1'b1;
    repeat (TMO) begin
      noise_inputs(1'b0);
      tick();
    end
    idle_inputs();
  endtask

  task automatic halt_idle(input int n);
    repeat (n) begin
      noise_inputs(1'($urandom));
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d cycles", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    idle_inputs();
    repeat (2) tick();
    do_reset();

    // Short program ending on the sentinel.
    load(0, 32'h2AF6_418E);
    load(1, 32'h76E0_9E51);
    load(2, HW);
    load(3, HW);
    start_run(1'b0, 0, 32'h0);
    exec_step(3, 1'b0, 32'h0, 32'h0);
    exec_step(0, 1'b0, 32'h0, 32'h0);
    halt_idle(6);

    // Processor overwrites the sentinel just ahead of the fetch.
    do_reset();
    start_run(1'b0, 0, 32'h0);
    exec_step(1, 1'b0, 32'h0, 32'h0);
    exec_step(0, 1'b1, 32'h0000_0102, 32'h7AF0_98FF);
    exec_step(2, 1'b0, 32'h0, 32'h0);
    halt_idle(4);

    // Stall until the timeout fires.
    do_reset();
    start_run(1'b0, 0, 32'h0);
    timeout_step();
    halt_idle(4);

    // Completion on the last allowed cycle, then reset during a write.
    do_reset();
    start_run(1'b0, 0, 32'h0);
    exec_step(TMO - 1, 1'b0, 32'h0, 32'h0);
    bus.sys_dne = 1'b1;
    bus.rw      = 1'b1;
    bus.addr    = 32'h0;
    bus.wdata   = 32'h1234_5678;
    do_reset();
    start_run(1'b0, 0, 32'h0);
    exec_step(0, 1'b0, 32'h0, 32'h0);
    exec_step(0, 1'b0, 32'h0, 32'h0);
    exec_step(0, 1'b0, 32'h0, 32'h0);

    // Full-depth random program with random stalls and writes; runs past
    // the pc wrap so word 0 is fetched again.
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) begin
      w = $urandom;
      if (w == HW) w = w ^ 32'h1;
      load(i, w);
    end
    w = $urandom;
    if (w == HW) w = w ^ 32'h1;
    start_run(1'b1, DEPTH - 1, w);
    for (int n = 0; n < 72; n++) begin
      if (!halt_m) begin
        w = $urandom;
        if (w == HW) w = w ^ 32'h1;
        exec_step(int'($urandom_range(0, TMO - 1)), ($urandom_range(0, 3) == 0),
                  $urandom, w);
      end
    end

    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/proc_mem_responder.md
PROC_MEM_RESPONDER -- requirements
Module: proc_mem_responder

Interface
REQ-001 SHALL provide parameter ADDR_W, default 6, word-address width; memory depth is 2^ADDR_W words.
REQ-002 SHALL provide parameter TIMEOUT, default 15, maximum EXEC cycles allowed without sys_dne.
REQ-003 SHALL provide parameter HALT_WORD, default 32'hFFFFFFFF, the program-end sentinel.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk in 1 (rising-edge clock), then reset in 1 (synchronous, active-high).
REQ-005 SHALL have ports: instruction out 32 (word presented to processor); addr in 32 (processor data address); wdata in 32 (processor data out); rw in 1 (1 = write, 0 = read); sys_dne in 1 (processor instruction complete).
REQ-006 SHALL have ports: ld_en in 1 (preload strobe); ld_addr in ADDR_W (preload address); ld_data in 32 (preload data); start in 1 (begin execution).
REQ-007 SHALL have ports: pc out ADDR_W (next fetch address); halted out 1 (sentinel reached); err out 1 (timeout occurred).

Function
REQ-008 SHALL use a 4-state FSM: LOAD, FETCH, EXEC, HALT.
REQ-009 In LOAD, ld_en=1 SHALL write ld_data into mem[ld_addr] at the clock edge; ld_en SHALL be ignored in every other state.
REQ-010 In LOAD, start=1 SHALL move the FSM to FETCH on the next edge; if ld_en and start are both high, the write SHALL commit and the FSM SHALL still move to FETCH; start SHALL be ignored outside LOAD.
REQ-011 In FETCH, if mem[pc] is not HALT_WORD, the block SHALL register instruction <= mem[pc] and pc <= pc+1, and go to EXEC.
REQ-012 Instruction SHALL be valid exactly 1 cycle after FETCH is entered and SHALL be held stable throughout EXEC.
REQ-013 In FETCH, if mem[pc] is HALT_WORD, the block SHALL set instruction <= 0 and halted <= 1, SHALL leave pc unchanged, and SHALL go to HALT.
REQ-014 pc SHALL wrap from 2^ADDR_W-1 to 0 with no flag.
REQ-015 In EXEC, sys_dne=1 SHALL go to FETCH on the next edge; if rw=1 in the same cycle, mem[addr[ADDR_W-1:0]] <= wdata SHALL commit on that edge.
REQ-016 Upper addr bits SHALL be ignored; rw and wdata SHALL be ignored whenever sys_dne=0 or the state is not EXEC.
REQ-017 A write to mem[pc] committed on the EXEC->FETCH edge SHALL be visible to the immediately following FETCH (write-before-read).
REQ-018 An EXEC cycle counter SHALL clear on entry to EXEC and increment each EXEC cycle without sys_dne.
REQ-019 When the counter reaches TIMEOUT with sys_dne=0, the block SHALL set err <= 1 and halted <= 1, set instruction <= 0, and go to HALT; if sys_dne=1 on that same cycle, sys_dne SHALL win and no error is raised.
REQ-020 HALT SHALL be absorbing until reset; all inputs SHALL be ignored there.

Reset
REQ-021 Reset SHALL put the FSM in LOAD and set pc=0, instruction=32'h0, halted=0, err=0, and the counter to 0, on the next rising edge.
REQ-022 Reset SHALL take priority over every other input in any state, including mid-EXEC with sys_dne=1 and rw=1; that write SHALL NOT commit.
REQ-023 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-024 A shared package proc_mem_pkg SHALL hold the state encoding (LOAD=0, FETCH=1, EXEC=2, HALT=3), the default ADDR_W, TIMEOUT and HALT_WORD, and the rw encoding constants.
REQ-025 The storage SHALL be one sub-module, proc_mem_array: 2^ADDR_W x 32, one synchronous write port (muxed between load and processor), and one asynchronous read port addressed by pc.

Verification
REQ-026 Preload is mem[0]=2AF6418E, mem[1]=76E09E51, mem[2]=FFFFFFFF; pulse start; hold sys_dne=0. Required: instruction=2AF6418E and pc=1 one cycle after FETCH.
REQ-027 Continuing REQ-026, pulse sys_dne=1 with rw=0. Required: instruction=76E09E51, pc=2; on the next sys_dne, halted=1, instruction=0, pc=2.
REQ-028 In EXEC, apply sys_dne=1, rw=1, addr=32'h00000102, wdata=7AF098FF. Required: mem[2]=7AF098FF, and it is fetched next in place of HALT_WORD.
REQ-029 Hold sys_dne=0 for 15 EXEC cycles. Required: err=1, halted=1, instruction=0; a repeat with sys_dne=1 on the 15th cycle gives err=0 and FETCH.
REQ-030 Assert reset mid-EXEC with sys_dne=1 and rw=1. Required: FSM in LOAD, pc=0, outputs zero, target word unchanged, preloaded program intact.
REQ-031 Preload all 64 words with non-sentinel values and run 64 instructions. Required: pc wraps 63->0, and word 0 is fetched again.
